// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: FSM states, major codes
// and instruction field positions.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [3:0] MAJ_REG  = 4'h0;
    localparam logic [3:0] MAJ_RSVD = 4'hF;

    localparam int MAJ_HI  = 15;
    localparam int MAJ_LO  = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 8;
    localparam int EXT_HI  = 7;
    localparam int EXT_LO  = 4;
    localparam int RS_HI   = 3;
    localparam int RS_LO   = 0;
    localparam int IMM_HI  = 7;

endpackage

// File: rtl/alu_ctrl_sequencer_instr_decode.sv
// Combinational instruction decoder: splits a 16-bit word into the datapath
// control fields and flags reserved and no-write-back instructions.
module instr_decode
    import alu_ctrl_pkg::*;
#(
    parameter logic [3:0] NOWB_EXT = 4'hB
) (
    input  logic [15:0] i_instr,
    output logic [7:0]  o_opcode,
    output logic [4:0]  o_control1,
    output logic [4:0]  o_control2,
    output logic        o_imm_control,
    output logic [15:0] o_immediate,
    output logic        o_illegal_raw,
    output logic        o_no_wb
);

    logic [3:0] w_major;
    logic [3:0] w_ext;

    assign w_major = i_instr[MAJ_HI:MAJ_LO];
    assign w_ext   = i_instr[EXT_HI:EXT_LO];

    always_comb begin
        o_control1    = {1'b0, i_instr[RD_HI:RD_LO]};
        o_opcode      = {4'h0, w_ext};
        o_control2    = {1'b0, i_instr[RS_HI:RS_LO]};
        o_imm_control = 1'b0;
        o_immediate   = 16'h0000;
        o_illegal_raw = (w_major == MAJ_RSVD);
        o_no_wb       = (w_ext == NOWB_EXT);
        if (w_major != MAJ_REG) begin
            // Immediate form: the major code selects the operation, ext bits become imm.
            o_opcode      = {w_major, 4'h0};
            o_control2    = 5'd0;
            o_imm_control = 1'b1;
            o_immediate   = {{8{i_instr[IMM_HI]}}, i_instr[IMM_HI:0]};
            o_no_wb       = (w_major == NOWB_EXT);
        end
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle control sequencer for the ALU datapath: accepts one instruction
// at a time and walks it through DECODE, EXEC and a single write-back cycle.
module alu_ctrl_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int         EXEC_CYCLES = 1,
    parameter logic [3:0] NOWB_EXT    = 4'hB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] enable,
    output logic [4:0]  control1,
    output logic [4:0]  control2,
    output logic        imm_control,
    output logic [7:0]  opcode,
    output logic [15:0] immediate,
    output logic        buff_en,
    output logic        done,
    output logic        illegal
);

    localparam logic [3:0] EXEC_RELOAD = 4'(EXEC_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_instr;
    logic [4:0]  r_control1;
    logic [4:0]  r_control2;
    logic        r_imm_control;
    logic [7:0]  r_opcode;
    logic [15:0] r_immediate;
    logic        r_no_wb;

    logic [7:0]  w_opcode;
    logic [4:0]  w_control1;
    logic [4:0]  w_control2;
    logic        w_imm_control;
    logic [15:0] w_immediate;
    logic        w_illegal_raw;
    logic        w_no_wb;

    instr_decode #(
        .NOWB_EXT (NOWB_EXT)
    ) u_decode (
        .i_instr       (r_instr),
        .o_opcode      (w_opcode),
        .o_control1    (w_control1),
        .o_control2    (w_control2),
        .o_imm_control (w_imm_control),
        .o_immediate   (w_immediate),
        .o_illegal_raw (w_illegal_raw),
        .o_no_wb       (w_no_wb)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_instr       <= 16'h0000;
            r_control1    <= 5'd0;
            r_control2    <= 5'd0;
            r_imm_control <= 1'b0;
            r_opcode      <= 8'h00;
            r_immediate   <= 16'h0000;
            r_no_wb       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) r_instr <= instr;
                end
                ST_DECODE: begin
                    // Rejected words leave the previously driven fields untouched.
                    if (!w_illegal_raw) begin
                        r_control1    <= w_control1;
                        r_control2    <= w_control2;
                        r_imm_control <= w_imm_control;
                        r_opcode      <= w_opcode;
                        r_immediate   <= w_immediate;
                        r_no_wb       <= w_no_wb;
                        r_cnt         <= EXEC_RELOAD;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (instr_valid) w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = w_illegal_raw ? ST_IDLE : ST_EXEC;
            ST_EXEC:   if (r_cnt == 4'd0) w_next_state = ST_WB;
            ST_WB:     w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Readiness is gated by reset so nothing is advertised while reset is held.
    assign instr_ready = (r_state == ST_IDLE) && reset;
    assign buff_en     = (r_state == ST_EXEC) || (r_state == ST_WB);
    assign done        = (r_state == ST_WB);
    assign illegal     = (r_state == ST_DECODE) && w_illegal_raw;
    assign enable      = ((r_state == ST_WB) && !r_no_wb) ? (16'h0001 << r_control1[3:0]) : 16'h0000;

    assign control1    = r_control1;
    assign control2    = r_control2;
    assign imm_control = r_imm_control;
    assign opcode      = r_opcode;
    assign immediate   = r_immediate;

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Control-side counterpart to the ALU datapath.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes each one.
- Sequences the datapath control bundle through a multi-cycle FSM: register-bank enables, the two source-mux selects, the immediate-mux select, ALU opcode, immediate value and tri-state buffer enable.
- Exactly one instruction is in flight at a time; each completes with a single-cycle register-bank write.

Parameters:
- EXEC_CYCLES, 1, cycles the ALU result is driven onto the bus before write-back (1..15).
- NOWB_EXT, 4'hB, ext code (register form) or major code (immediate form) for compare: executes with no write-back.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- instr  input  16  instruction word
- instr_valid  input  1  instr is valid
- instr_ready  output  1  sequencer can accept an instruction
- enable  output  16  one-hot register-bank write enable
- control1  output  5  source-mux-1 select (Rdest)
- control2  output  5  source-mux-2 select (Rsrc)
- imm_control  output  1  1 = immediate replaces mux-2 output
- opcode  output  8  ALU opcode
- immediate  output  16  sign-extended immediate
- buff_en  output  1  ALU-to-bus tri-state enable
- done  output  1  one-cycle pulse when an instruction retires
- illegal  output  1  one-cycle pulse when an instruction is rejected

Behaviour:
- Instruction format: [15:12] major, [11:8] Rdest, [7:4] ext, [3:0] Rsrc/imm-low; immediate = {{8{instr[7]}}, instr[7:0]}.
- Register form (major = 0):
  - opcode = {4'h0, ext}, imm_control = 0.
  - control2 = {1'b0, Rsrc}, immediate = 0.
- Immediate form (major 1..E):
  - opcode = {major, 4'h0}, imm_control = 1.
  - control2 = 0, immediate = sign-extended instr[7:0].
- Reserved form (major = F): illegal.
- control1 = {1'b0, Rdest} in both legal forms.
- States:
  - IDLE
    - instr_ready = 1.
    - On instr_valid && instr_ready: latch instr, go to DECODE.
  - DECODE (1 cycle)
    - Register all decoded outputs.
    - If major = F: pulse illegal, go to IDLE; no enable and no buff_en.
  - EXEC (EXEC_CYCLES cycles, 4-bit down-counter)
    - buff_en = 1; decoded outputs held stable.
  - WB (1 cycle)
    - buff_en = 1.
    - enable = 16'h0001 << Rdest, unless a no-write-back compare, in which case enable = 0.
    - Pulse done, go to IDLE.
- instr_ready is 0 in every state except IDLE; instr_valid outside IDLE is ignored; no buffering.
- Latency with EXEC_CYCLES = 1: accept at edge N, enable is high during cycle N+3, done is asserted in the same cycle, and instr_ready returns in cycle N+4.
- Minimum back-to-back issue interval: EXEC_CYCLES + 3 cycles.
- Every enable is exactly one-hot or all-zero; never more than one bit set.
- In IDLE:
  - control1, control2, opcode, immediate, imm_control hold their last values.
  - enable = 0, buff_en = 0.
- Reset (reset = 0 at a rising edge) overrides all other inputs, including mid-EXEC and mid-WB:
  - state = IDLE, counter = 0.
  - All outputs 0, except instr_ready = 1 on the first cycle after reset is released.
  - An in-flight instruction is discarded and no enable is produced.
- The down-counter reloads with EXEC_CYCLES-1 on entry to EXEC; EXEC exits when the counter = 0 (no wrap-around).

Decomposition:
- Shared package alu_ctrl_pkg:
  - State encoding (IDLE, DECODE, EXEC, WB).
  - Major-code constants: MAJ_REG = 4'h0, MAJ_RSVD = 4'hF.
  - Instruction field bit positions.
- One natural sub-module, instr_decode: combinational, instr -> opcode, control1, control2, imm_control, immediate, illegal_raw, no_wb.
- The FSM, counter and output registers stay in the top level.

Test Plan:
- Register ADD: reset low 2 cycles, then instr = 16'h0351 → opcode = 8'h05, control1 = 3, control2 = 1, imm_control = 0; enable = 16'h0008 exactly one cycle; done in the same cycle.
- Immediate negative: instr = 16'h52FE → opcode = 8'h50, imm_control = 1, immediate = 16'hFFFE, enable = 16'h0004.
- Compare, no write-back: instr = 16'h01B2 → buff_en pulses, enable stays 0 throughout, done = 1.
- Illegal: instr = 16'hF123 → illegal pulses one cycle after accept; enable = 0, buff_en = 0; instr_ready = 1 on the next cycle.
- Busy and back-to-back: hold instr_valid high with two words.
  - Second word is accepted only when instr_ready returns, 4 cycles after the first accept.
  - The second word is ignored while busy.
- Reset mid-EXEC: with EXEC_CYCLES = 3, drop reset during the 2nd EXEC cycle → next cycle all outputs 0, state IDLE, no enable observed.
